audio_pdm_tx: RTL



---
 rtl/audio_pdm_tx.sv | 249 ++++++++++++++++++++++++
 1 files changed

// File: rtl/audio_pdm_tx.sv
// -----------------------------------------------------------------------------
// audio_pdm_tx
//
// Purpose:
//   Converts a stream of signed 16-bit PCM samples into a 1-bit PDM bitstream
//   for a speaker or class-D output stage. It is the transmit-side counterpart
//   of the PDM microphone path and runs from the shared PDM-bit and
//   PCM-sample strobes on the same clock.
//
//   Pipeline:
//     1. One-entry sample buffer with a valid/ready handshake.
//     2. Zero-order hold: the current sample is held for a whole sample
//        period and is only replaced on a sample-period boundary.
//     3. Second-order sigma-delta modulator with saturating integrators.
//
// Parameters:
//   W             integrator width in bits, signed (valid range 20..32)
//
// Ports:
//   clk           in   1   system clock
//   rst           in   1   synchronous active-high reset
//   stb_pdm       in   1   one-cycle strobe: one modulator step / PDM bit
//   stb_pcm       in   1   one-cycle strobe: sample-period boundary
//   pcm_in        in   16  signed PCM sample
//   pcm_valid     in   1   pcm_in valid
//   pcm_ready     out  1   buffer can accept (combinational)
//   mute          in   1   force modulator input to 0
//   pdm_out       out  1   registered PDM bit
//   underrun      out  1   one-cycle pulse: sample period started with no data
//   underrun_cnt  out  8   saturating underrun counter
//
// Configuration macro:
//   AUDIO_PDM_TX_DITHER_EN  when defined, a 16-bit Galois LFSR supplies a
//                           +/-1 dither term to the second integrator. When
//                           undefined the dither term is 0 and no LFSR
//                           exists.
// -----------------------------------------------------------------------------
module audio_pdm_tx #(
    parameter int W = 24
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               stb_pdm,
    input  logic               stb_pcm,
    input  logic signed [15:0] pcm_in,
    input  logic               pcm_valid,
    output logic               pcm_ready,
    input  logic               mute,
    output logic               pdm_out,
    output logic               underrun,
    output logic [7:0]         underrun_cnt
);

    // Intermediate sums carry two guard bits so that i + i + fb + d can
    // never wrap before it is clamped back to W bits.
    localparam int SW = W + 2;

    // Integrator clamp limits: +/-(2^(W-1)-1), expressed at SW bits. Built
    // from bit patterns so that W=32 does not overflow 32-bit int arithmetic.
    localparam logic signed [SW-1:0] SAT_MAX = {3'b000, {(W-1){1'b1}}};
    localparam logic signed [SW-1:0] SAT_MIN = {3'b111, {(W-2){1'b0}}, 1'b1};

    // Feedback magnitude equals full scale of the 16-bit input (2^15).
    localparam logic signed [SW-1:0] FB_MAG = {{(SW-17){1'b0}}, 17'h08000};

    // Input is clamped to 75 % of full scale; beyond this a second-order
    // loop with this feedback level is no longer guaranteed stable.
    localparam logic signed [15:0] X_LIM = 16'sd24576;

    // -------------------------------------------------------------------------
    // State
    // -------------------------------------------------------------------------
    logic signed [15:0]  buf_q,        buf_d;
    logic                buf_full_q,   buf_full_d;
    logic signed [15:0]  cur_q,        cur_d;
    logic                underrun_q,   underrun_d;
    logic [7:0]          under_cnt_q,  under_cnt_d;
    logic signed [W-1:0] i1_q,         i1_d;
    logic signed [W-1:0] i2_q,         i2_d;
    logic                pdm_q,        pdm_d;

    // -------------------------------------------------------------------------
    // Handshake / buffer / zero-order hold
    // -------------------------------------------------------------------------
    logic accept;

    // Ready is held low during reset so no sample is accepted into a buffer
    // that is being cleared on the same edge.
    assign pcm_ready = ~buf_full_q & ~rst;
    assign accept    = pcm_valid & pcm_ready;

    always_comb begin
        buf_d       = buf_q;
        buf_full_d  = buf_full_q;
        cur_d       = cur_q;
        underrun_d  = 1'b0;
        under_cnt_d = under_cnt_q;

        if (accept) begin
            buf_d      = pcm_in;
            buf_full_d = 1'b1;
        end

        if (stb_pcm) begin
            if (buf_full_q) begin
                // accept cannot be high here: ready is low while full.
                cur_d      = buf_q;
                buf_full_d = 1'b0;
            end else if (accept) begin
                // Bypass: the sample arriving on the boundary goes straight
                // to the hold register and never occupies the buffer.
                cur_d      = pcm_in;
                buf_full_d = 1'b0;
            end else begin
                // No data for this period: keep the previous sample.
                underrun_d = 1'b1;
                if (under_cnt_q != 8'hFF) begin
                    under_cnt_d = under_cnt_q + 8'd1;
                end
            end
        end
    end

    // -------------------------------------------------------------------------
    // Optional dither source
    // -------------------------------------------------------------------------
    logic signed [SW-1:0] dith;

`ifdef AUDIO_PDM_TX_DITHER_EN
    // Galois LFSR, x^16 + x^14 + x^13 + x^11 + 1, right-shifting form.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    localparam logic signed [SW-1:0] DITH_ONE = {{(SW-1){1'b0}}, 1'b1};

    logic [15:0] lfsr_q, lfsr_d;
    logic [15:0] lfsr_shift;

    genvar gi;
    generate
        for (gi = 0; gi < 16; gi++) begin : g_lfsr
            if (gi == 15) begin : g_top
                assign lfsr_shift[gi] = lfsr_q[0] & LFSR_TAPS[gi];
            end else begin : g_mid
                assign lfsr_shift[gi] = lfsr_q[gi+1] ^ (lfsr_q[0] & LFSR_TAPS[gi]);
            end
        end
    endgenerate

    assign lfsr_d = stb_pdm ? lfsr_shift : lfsr_q;
    assign dith   = lfsr_q[0] ? DITH_ONE : -DITH_ONE;

    always_ff @(posedge clk) begin
        if (rst) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end
`else
    assign dith = '0;
`endif

    // -------------------------------------------------------------------------
    // Second-order sigma-delta modulator
    // -------------------------------------------------------------------------
    function automatic logic signed [W-1:0] sat(input logic signed [SW-1:0] v);
        if (v > SAT_MAX) begin
            return SAT_MAX[W-1:0];
        end else if (v < SAT_MIN) begin
            return SAT_MIN[W-1:0];
        end else begin
            return v[W-1:0];
        end
    endfunction

    logic signed [15:0]   x_clamped;
    logic signed [SW-1:0] x_ext;
    logic signed [SW-1:0] i1_ext;
    logic signed [SW-1:0] i2_ext;
    logic signed [SW-1:0] fb;
    logic signed [SW-1:0] sum1;
    logic signed [SW-1:0] sum2;
    logic                 y;

    always_comb begin
        if (mute) begin
            x_clamped = '0;
        end else if (cur_q > X_LIM) begin
            x_clamped = X_LIM;
        end else if (cur_q < -X_LIM) begin
            x_clamped = -X_LIM;
        end else begin
            x_clamped = cur_q;
        end
    end

    assign x_ext  = {{(SW-16){x_clamped[15]}}, x_clamped};
    assign i1_ext = {{2{i1_q[W-1]}}, i1_q};
    assign i2_ext = {{2{i2_q[W-1]}}, i2_q};

    // Quantiser: output 1 whenever the second integrator is non-negative.
    assign y  = ~i2_q[W-1];
    assign fb = y ? FB_MAG : -FB_MAG;

    // Second integrator consumes the pre-update first integrator value.
    assign sum1 = i1_ext + x_ext - fb;
    assign sum2 = i2_ext + i1_ext - fb + dith;

    always_comb begin
        i1_d  = i1_q;
        i2_d  = i2_q;
        pdm_d = pdm_q;
        if (stb_pdm) begin
            i1_d  = sat(sum1);
            i2_d  = sat(sum2);
            pdm_d = y;
        end
    end

    // -------------------------------------------------------------------------
    // State registers
    // -------------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            buf_q       <= '0;
            buf_full_q  <= 1'b0;
            cur_q       <= '0;
            underrun_q  <= 1'b0;
            under_cnt_q <= '0;
            i1_q        <= '0;
            i2_q        <= '0;
            pdm_q       <= 1'b0;
        end else begin
            buf_q       <= buf_d;
            buf_full_q  <= buf_full_d;
            cur_q       <= cur_d;
            underrun_q  <= underrun_d;
            under_cnt_q <= under_cnt_d;
            i1_q        <= i1_d;
            i2_q        <= i2_d;
            pdm_q       <= pdm_d;
        end
    end

    assign pdm_out      = pdm_q;
    assign underrun     = underrun_q;
    assign underrun_cnt = under_cnt_q;

endmodule
